inst_encoder: RTL and testbench
===============================

# inst_encoder

Instruction encoder that packs decoded RISC-V fields (format, registers, funct3, 32-bit immediate) into 32-bit instruction words. It is the inverse of the core's immediate generator: it scatters the immediate into I/S/B/J bit positions and range-checks it. It also expands the `li` pseudo-instruction into LUI+ADDI. It sits in the boot/test loader path and feeds instruction memory through a valid/ready stream.

## Interface
- No parameters.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_fmt`  in  3  0=LOAD, 1=STORE, 2=BRANCH, 3=OPIMM, 4=JAL, 5=JALR, 6=LI; 7 reserved
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices
- `req_funct3`  in  3  funct3 field (ignored for JAL and LI; JALR forces 000)
- `req_imm`  in  32  signed immediate / byte offset
- `inst_valid`  out  1  `inst_code` holds a valid word
- `inst_ready`  in  1  consumer takes the word when `inst_valid && inst_ready`
- `inst_code`  out  32  encoded instruction
- `err`  out  1  one-cycle pulse: request rejected

## Operation
- FSM with three states:
  - IDLE: `req_ready = !reset`.
  - EMIT: one word pending.
  - EMIT_HI: LUI pending, ADDI queued in an internal `lo_word` register.
- Opcodes: LOAD 0000011, STORE 0100011, BRANCH 1100011, OPIMM 0010011, JAL 1101111, JALR 1100111, LUI 0110111.
- Encodings:
  - LOAD, OPIMM, JALR (I-type): imm[11:0] goes to bits [31:20].
  - STORE: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - BRANCH: imm[12|10:5] to [31|30:25], imm[4:1|11] to [11:8|7].
  - JAL: imm[20|10:1|11|19:12] to [31|30:21|20|19:12].
  - Register fields: rd [11:7], rs1 [19:15], rs2 [24:20], funct3 [14:12]; fields a format does not use are zero.
- Range checks on signed `req_imm`:
  - I and S formats: -2048..2047.
  - BRANCH: -4096..4094, and imm[0] must be 0.
  - JAL: -1048576..1048574, and imm[0] must be 0.
- LI handling:
  - `lo = sext(imm[11:0])`, `hi = (imm + 0x800) >> 12` (32-bit wrap, take bits [31:12]).
  - If `imm` fits in -2048..2047: emit ADDI rd, x0, imm.
  - Else if imm[11:0] == 0: emit LUI rd, hi only.
  - Else: emit LUI rd, hi, then ADDI rd, rd, lo.
  - LI never errors; `imm` = 0x7FFFF800..0x7FFFFFFF wraps hi to 0x80000 (correct under 32-bit arithmetic).
- Rejection: an out-of-range or misaligned immediate, or fmt=7, is consumed in IDLE. The block pulses `err` for 1 cycle, emits no word, and stays in IDLE.
- Transitions:
  - IDLE + accept (valid request) goes to EMIT, or to EMIT_HI for two-word LI.
  - EMIT + `inst_ready` goes to IDLE.
  - EMIT_HI + `inst_ready` loads `lo_word` into `inst_code` and goes to EMIT.
- `rd` = x0 is encoded as given (no special case).

## Timing
- Reset values: `inst_valid`=0, `inst_code`=0, `err`=0, state IDLE, `lo_word`=0. `req_ready`=0 while `reset` is high.
- Accept in cycle N: `inst_valid`=1 with the first word in cycle N+1. A rejected request gives `err`=1 in cycle N+1 only.
- `inst_code` and `inst_valid` are registered and held stable while `inst_valid && !inst_ready`.
- `req_ready` is 0 whenever the state is not IDLE, so there is no overlap between a pending word and a new request. Peak throughput is one word per 2 cycles.
- Two-word LI: LUI appears at N+1. ADDI appears the cycle after the LUI handshake, back-to-back when `inst_ready` is held high.
- `reset` mid-operation: the next cycle is IDLE with `inst_valid`=0. A pending or queued word is discarded, not emitted.
- Inputs are sampled only in the accept cycle; changes afterwards have no effect.

## Test plan
- OPIMM LI x1, imm=0xFFFFFFFF -> single word 0xFFF00093 at N+1, then IDLE.
- LI x5, imm=0x12345678 with `inst_ready`=1 -> 0x123452B7, then 0x67828293 on consecutive cycles. LI x1, imm=0x800 -> 0x000010B7, then 0x80008093.
- LI x2, imm=0x00010000 -> LUI only, 0x00010137. STORE rs1=1, rs2=2, funct3=010, imm=12 -> 0x0020A623.
- BRANCH rs1=1, rs2=2, funct3=000, imm=8 -> 0x00208463. JAL rd=1, imm=0x800 -> 0x001000EF. BRANCH imm=5 -> `err` pulse at N+1, no `inst_valid`.
- Backpressure: hold `inst_ready`=0 for 3 cycles during a two-word LI -> LUI word stable, `req_ready`=0 throughout, ADDI follows the first handshake.
- Assert `reset` while in EMIT_HI -> `inst_valid`=0 next cycle, queued ADDI never appears, `req_ready`=1 after `reset` deasserts.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RISC-V fields into 32-bit instruction words,
// range-checks immediates and expands the li pseudo-instruction.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a word transfers on a rising edge where inst_valid && inst_ready. While
// inst_valid is high and inst_ready is low, inst_code and inst_valid hold.
// req_ready is high only in IDLE and only while reset is low.
module inst_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_EMIT_HI = 2'd2
  } state_t;

  localparam logic [2:0] FMT_LOAD   = 3'd0;
  localparam logic [2:0] FMT_STORE  = 3'd1;
  localparam logic [2:0] FMT_BRANCH = 3'd2;
  localparam logic [2:0] FMT_OPIMM  = 3'd3;
  localparam logic [2:0] FMT_JAL    = 3'd4;
  localparam logic [2:0] FMT_JALR   = 3'd5;
  localparam logic [2:0] FMT_LI     = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_inst_valid;
  logic        w_valid_nxt;
  logic [31:0] r_inst_code;
  logic [31:0] w_code_nxt;
  logic [31:0] r_lo_word;
  logic [31:0] w_lo_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic [19:0] w_hi;
  logic [31:0] w_first;
  logic [31:0] w_second;
  logic        w_ok;
  logic        w_two;

  assign req_ready  = (r_state == ST_IDLE) && !reset;
  assign inst_valid = r_inst_valid;
  assign inst_code  = r_inst_code;
  assign err        = r_err;
  assign dbg_state  = r_state;

  // Encode the presented request: legality, first word and optional ADDI word.
  always_comb begin
    // Signed range checks reduce to "all bits above the field are copies of the sign".
    w_fits12 = (req_imm[31:11] == 21'd0) || (req_imm[31:11] == {21{1'b1}});
    w_fits13 = (req_imm[31:12] == 20'd0) || (req_imm[31:12] == {20{1'b1}});
    w_fits21 = (req_imm[31:20] == 12'd0) || (req_imm[31:20] == {12{1'b1}});
    // (imm + 0x800) >> 12: the +0x800 carries into bit 12 exactly when imm[11] is set.
    w_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
    w_first  = '0;
    w_second = '0;
    w_ok     = 1'b0;
    w_two    = 1'b0;
    case (req_fmt)
      FMT_LOAD: begin
        w_ok    = w_fits12;
        w_first = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
      end
      FMT_OPIMM: begin
        w_ok    = w_fits12;
        w_first = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_OPIMM};
      end
      FMT_JALR: begin
        w_ok    = w_fits12;
        w_first = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
      end
      FMT_STORE: begin
        w_ok    = w_fits12;
        w_first = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
      end
      FMT_BRANCH: begin
        w_ok    = w_fits13 && !req_imm[0];
        w_first = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:1], req_imm[11], OP_BRANCH};
      end
      FMT_JAL: begin
        w_ok    = w_fits21 && !req_imm[0];
        w_first = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
      end
      FMT_LI: begin
        w_ok = 1'b1;
        if (w_fits12) begin
          w_first = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_OPIMM};
        end else begin
          w_first = {w_hi, req_rd, OP_LUI};
          if (req_imm[11:0] != 12'd0) begin
            w_two    = 1'b1;
            w_second = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_OPIMM};
          end
        end
      end
      default: w_ok = 1'b0;
    endcase
  end

  // Next-state and next-output logic of the emit FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_inst_valid;
    w_code_nxt  = r_inst_code;
    w_lo_nxt    = r_lo_word;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_ok) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_first;
            if (w_two) begin
              w_lo_nxt    = w_second;
              w_state_nxt = ST_EMIT_HI;
            end else begin
              w_state_nxt = ST_EMIT;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (inst_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT_HI: begin
        if (inst_ready) begin
          w_code_nxt  = r_lo_word;
          w_state_nxt = ST_EMIT;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any pending or queued word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_inst_valid <= 1'b0;
      r_inst_code  <= '0;
      r_lo_word    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_inst_valid <= w_valid_nxt;
      r_inst_code  <= w_code_nxt;
      r_lo_word    <= w_lo_nxt;
      r_err        <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed steps from known encodings, then
// randomized requests checked against an arithmetic reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_code;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  inst_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_funct3 (req_funct3),
    .req_imm    (req_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_code  (inst_code),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns legality and pushes the expected word(s).
  function automatic bit model(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    int         si;
    bit [31:0]  u;
    bit [31:0]  w_rd;
    bit [31:0]  w_rs1;
    bit [31:0]  w_rs2;
    bit [31:0]  w_f3;
    bit [31:0]  h;
    bit         ok;
    si    = imm;
    u     = imm;
    w_rd  = 32'(rd);
    w_rs1 = 32'(rs1);
    w_rs2 = 32'(rs2);
    w_f3  = 32'(f3);
    ok    = 1'b0;
    case (fmt)
      3'd0, 3'd3, 3'd5: begin
        ok = (si >= -2048) && (si <= 2047);
        if (ok) exp_q.push_back(((u & 32'hfff) << 20) | (w_rs1 << 15) |
                                ((fmt == 3'd5) ? 32'd0 : (w_f3 << 12)) | (w_rd << 7) |
                                ((fmt == 3'd0) ? 32'h03 : (fmt == 3'd3) ? 32'h13 : 32'h67));
      end
      3'd1: begin
        ok = (si >= -2048) && (si <= 2047);
        if (ok) exp_q.push_back((((u >> 5) & 32'h7f) << 25) | (w_rs2 << 20) | (w_rs1 << 15) |
                                (w_f3 << 12) | ((u & 32'h1f) << 7) | 32'h23);
      end
      3'd2: begin
        ok = (si >= -4096) && (si <= 4094) && ((u & 1) == 0);
        if (ok) exp_q.push_back((((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) |
                                (w_rs2 << 20) | (w_rs1 << 15) | (w_f3 << 12) |
                                (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63);
      end
      3'd4: begin
        ok = (si >= -1048576) && (si <= 1048574) && ((u & 1) == 0);
        if (ok) exp_q.push_back((((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                                (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) |
                                (w_rd << 7) | 32'h6f);
      end
      3'd6: begin
        ok = 1'b1;
        if ((si >= -2048) && (si <= 2047)) begin
          exp_q.push_back(((u & 32'hfff) << 20) | (w_rd << 7) | 32'h13);
        end else begin
          h = (u + 32'h800) >> 12;
          exp_q.push_back((h << 12) | (w_rd << 7) | 32'h37);
          if ((u & 32'hfff) != 0)
            exp_q.push_back(((u & 32'hfff) << 20) | (w_rd << 15) | (w_rd << 7) | 32'h13);
        end
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Present one request for a single cycle, then scramble the fields.
  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_fmt    = fmt;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_imm    = imm;
    tick();
    req_valid  = 1'b0;
    req_fmt    = 3'($urandom);
    req_rd     = 5'($urandom);
    req_rs1    = 5'($urandom);
    req_rs2    = 5'($urandom);
    req_funct3 = 3'($urandom);
    req_imm    = $urandom;
  endtask

  // Rejected request: one-cycle err pulse, no word, back in IDLE.
  task automatic expect_err();
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_no_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("err_cleared", {31'd0, err}, 32'd0);
    check("err_no_valid2", {31'd0, inst_valid}, 32'd0);
    check("err_idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Consume every queued word, stalling stalls0 cycles on the first word and
  // a random 0..rnd_max cycles on the rest.
  task automatic drain(input int stalls0, input int rnd_max);
    int k;
    int st;
    k = 0;
    while (exp_q.size() > 0 && k < 4) begin
      st = (k == 0) ? stalls0 : int'($urandom_range(0, rnd_max));
      for (int s = 0; s <= st; s++) begin
        check("word_valid", {31'd0, inst_valid}, 32'd1);
        check("word_code", inst_code, exp_q[0]);
        check("busy_ready", {31'd0, req_ready}, 32'd0);
        check("word_no_err", {31'd0, err}, 32'd0);
        inst_ready = (s == st);
        tick();
      end
      inst_ready = 1'b0;
      void'(exp_q.pop_front());
      k++;
    end
    if (exp_q.size() > 0) begin
      check("drain_leftover", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    check("done_valid", {31'd0, inst_valid}, 32'd0);
    check("done_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Stimulus
  initial begin
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          ok;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_fmt    = '0;
    req_rd     = '0;
    req_rs1    = '0;
    req_rs2    = '0;
    req_funct3 = '0;
    req_imm    = '0;
    inst_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_code", inst_code, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // li x1, -1 -> single ADDI
    exp_q.push_back(32'hFFF00093);
    send(3'd6, 5'd1, 5'd9, 5'd9, 3'd7, 32'hFFFFFFFF);
    drain(0, 0);

    // li x5, 0x12345678 -> LUI then ADDI back to back
    exp_q.push_back(32'h123452B7);
    exp_q.push_back(32'h67828293);
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678);
    drain(0, 0);

    // li x1, 0x800 -> hi rounds up, lo is negative
    exp_q.push_back(32'h000010B7);
    exp_q.push_back(32'h80008093);
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
    drain(0, 0);

    // li x2, 0x10000 -> LUI only
    exp_q.push_back(32'h00010137);
    send(3'd6, 5'd2, 5'd0, 5'd0, 3'd0, 32'h00010000);
    drain(0, 0);

    // li x3, 0x7FFFFFFF -> hi wraps to 0x80000
    exp_q.push_back(32'h800001B7);
    exp_q.push_back(32'hFFF18193);
    send(3'd6, 5'd3, 5'd0, 5'd0, 3'd0, 32'h7FFFFFFF);
    drain(0, 0);

    // sw x2, 12(x1); rd field is ignored
    exp_q.push_back(32'h0020A623);
    send(3'd1, 5'd7, 5'd1, 5'd2, 3'b010, 32'd12);
    drain(0, 0);

    // beq x1, x2, +8
    exp_q.push_back(32'h00208463);
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'b000, 32'd8);
    drain(0, 0);

    // jal x1, +0x800
    exp_q.push_back(32'h001000EF);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
    drain(0, 0);

    // misaligned branch, reserved format, I-type one past the limit
    send(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 32'd5);
    expect_err();
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0);
    expect_err();
    send(3'd3, 5'd1, 5'd1, 5'd1, 3'd0, 32'd2048);
    expect_err();

    // boundary immediates through the model
    ok = model(3'd3, 5'd4, 5'd6, 5'd0, 3'd1, 32'd2047);
    send(3'd3, 5'd4, 5'd6, 5'd0, 3'd1, 32'd2047);
    if (ok) drain(0, 0); else expect_err();
    ok = model(3'd0, 5'd4, 5'd6, 5'd0, 3'd2, 32'hFFFFF800);
    send(3'd0, 5'd4, 5'd6, 5'd0, 3'd2, 32'hFFFFF800);
    if (ok) drain(0, 0); else expect_err();
    ok = model(3'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd4094);
    send(3'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd4094);
    if (ok) drain(0, 0); else expect_err();
    ok = model(3'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd4096);
    send(3'd2, 5'd0, 5'd3, 5'd4, 3'd1, 32'd4096);
    if (ok) drain(0, 0); else expect_err();
    ok = model(3'd4, 5'd8, 5'd0, 5'd0, 3'd0, 32'hFFF00000);
    send(3'd4, 5'd8, 5'd0, 5'd0, 3'd0, 32'hFFF00000);
    if (ok) drain(0, 0); else expect_err();
    ok = model(3'd4, 5'd8, 5'd0, 5'd0, 3'd0, 32'd1048576);
    send(3'd4, 5'd8, 5'd0, 5'd0, 3'd0, 32'd1048576);
    if (ok) drain(0, 0); else expect_err();

    // backpressure: LUI held for 3 cycles, ADDI follows the handshake
    exp_q.push_back(32'h123452B7);
    exp_q.push_back(32'h67828293);
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678);
    drain(3, 0);

    // reset while the ADDI is queued
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345678);
    check("pre_rst_code", inst_code, 32'h123452B7);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("mid_rst_code", inst_code, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("after_rst_ready", {31'd0, req_ready}, 32'd1);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_queued_addi", {31'd0, inst_valid}, 32'd0);
    end
    inst_ready = 1'b0;

    // randomized requests against the model
    for (int i = 0; i < 300; i++) begin
      fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 10000)) - 5000);
        1: imm = $urandom;
        2: imm = 32'($signed($urandom_range(0, 2200000)) - 1100000);
        default: imm = 32'($signed($urandom_range(0, 16)) + 2040) ^ (($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd0);
      endcase
      req_rd     = 5'($urandom);
      req_rs1    = 5'($urandom);
      req_rs2    = 5'($urandom);
      req_funct3 = 3'($urandom);
      ok = model(fmt, req_rd, req_rs1, req_rs2, req_funct3, imm);
      send(fmt, req_rd, req_rs1, req_rs2, req_funct3, imm);
      if (ok) drain(int'($urandom_range(0, 2)), 2);
      else expect_err();
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
